// File: rtl/depacketizer_stream.sv
// Flit stream depacketizer: frames head/body/tail flits, checks declared length and
// buffers reassembled payload words (with last/abort markers) in an output FIFO.
module depacketizer_stream #(
  parameter int                 DATA_W    = 16,
  parameter int                 DEPTH     = 8,
  parameter logic [DATA_W-1:0]  HEAD_MARK = 16'hAAAA,
  parameter logic [DATA_W-1:0]  TAIL_MARK = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [3*DATA_W-1:0]   flit_in,
  input  logic                  flit_valid,
  output logic                  flit_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic                  out_abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_orphan,
  output logic                  err_len,
  output logic [15:0]           pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + 2;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [DATA_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t              state, state_nx;
  logic [DATA_W-1:0]   len_reg, len_nx;
  logic [DATA_W-1:0]   flit_count, cnt_nx, cnt_inc;
  logic [EW-1:0]       mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       occ;
  logic [1:0]          push_n;
  logic [EW-1:0]       e0, e1, head_entry;
  logic                orphan_nx, len_err_nx, pkt_inc;
  logic                accept, pop, is_head, is_tail;
  logic [DATA_W-1:0]   marker, payload, aux;

  assign marker  = flit_in[3*DATA_W-1:2*DATA_W];
  assign payload = flit_in[2*DATA_W-1:DATA_W];
  assign aux     = flit_in[DATA_W-1:0];
  assign is_head = (marker == HEAD_MARK);
  assign is_tail = (marker == TAIL_MARK);

  // Two free slots are required because a truncating head writes two entries at once.
  assign flit_ready = reset_n && ((DEPTH_C - occ) >= CW'(2));
  assign accept     = flit_valid && flit_ready;
  assign pop        = out_valid && out_ready;

  assign cnt_inc = (flit_count == CNT_MAX) ? CNT_MAX : flit_count + DATA_W'(1);

  always_comb begin
    state_nx   = state;
    len_nx     = len_reg;
    cnt_nx     = flit_count;
    push_n     = 2'd0;
    e0         = '0;
    e1         = '0;
    orphan_nx  = 1'b0;
    len_err_nx = 1'b0;
    pkt_inc    = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (is_head) begin
            e0       = {2'b00, payload};
            push_n   = 2'd1;
            len_nx   = aux;
            cnt_nx   = DATA_W'(1);
            state_nx = IN_PKT;
          end else begin
            orphan_nx = 1'b1;
          end
        end
        IN_PKT: begin
          if (is_head) begin
            // Truncated packet: close it with an abort filler, then open the new one.
            e0         = {2'b11, {DATA_W{1'b0}}};
            e1         = {2'b00, payload};
            push_n     = 2'd2;
            len_err_nx = 1'b1;
            len_nx     = aux;
            cnt_nx     = DATA_W'(1);
          end else if (is_tail) begin
            e0         = {2'b01, payload};
            push_n     = 2'd1;
            pkt_inc    = 1'b1;
            len_err_nx = (cnt_inc != len_reg);
            state_nx   = IDLE;
          end else begin
            e0     = {2'b00, payload};
            push_n = 2'd1;
            cnt_nx = cnt_inc;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      len_reg    <= '0;
      flit_count <= '0;
      err_orphan <= 1'b0;
      err_len    <= 1'b0;
      pkt_count  <= '0;
    end else begin
      state      <= state_nx;
      len_reg    <= len_nx;
      flit_count <= cnt_nx;
      err_orphan <= orphan_nx;
      err_len    <= len_err_nx;
      if (pkt_inc) pkt_count <= pkt_count + 16'd1;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem[wr_ptr] <= e0;
    if (push_n == 2'd2) mem[wr_ptr + AW'(1)] <= e1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_n);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      occ    <= occ + CW'(push_n) - CW'(pop);
    end
  end

  assign head_entry = mem[rd_ptr];
  assign out_valid  = (occ != '0);
  assign out_data   = out_valid ? head_entry[DATA_W-1:0] : '0;
  assign out_last   = out_valid && head_entry[DATA_W];
  assign out_abort  = out_valid && head_entry[DATA_W+1];

endmodule

// File: tb/tb_depacketizer_stream.sv
// Directed bench for depacketizer_stream: per-cycle vector table plus
// backpressure and mid-packet reset sequences.
module tb_depacketizer_stream;

  localparam logic [15:0] HM = 16'hAAAA;
  localparam logic [15:0] TM = 16'hFFFF;
  localparam logic [15:0] BM = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [47:0] flit_in;
  logic        flit_valid;
  logic        flit_ready;
  logic [15:0] out_data;
  logic        out_last, out_abort, out_valid, out_ready;
  logic        err_orphan, err_len;
  logic [15:0] pkt_count;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  depacketizer_stream dut (
    .clk(clk), .reset_n(reset_n), .flit_in(flit_in), .flit_valid(flit_valid),
    .flit_ready(flit_ready), .out_data(out_data), .out_last(out_last),
    .out_abort(out_abort), .out_valid(out_valid), .out_ready(out_ready),
    .err_orphan(err_orphan), .err_len(err_len), .pkt_count(pkt_count)
  );

  typedef struct {
    logic        vld;
    logic [15:0] mark, pay, aux;
    logic        ordy;
    logic        e_ov;
    logic [15:0] e_od;
    logic        e_ol, e_oa, e_eo, e_el, e_fr;
    logic [15:0] e_pc;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic vld, logic [15:0] mark, logic [15:0] pay, logic [15:0] aux,
                              logic e_ov, logic [15:0] e_od, logic e_ol, logic e_oa,
                              logic e_eo, logic e_el, logic [15:0] e_pc);
    vec_t v;
    v.vld = vld; v.mark = mark; v.pay = pay; v.aux = aux; v.ordy = 1'b1;
    v.e_ov = e_ov; v.e_od = e_od; v.e_ol = e_ol; v.e_oa = e_oa;
    v.e_eo = e_eo; v.e_el = e_el; v.e_fr = 1'b1; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; flit_valid = 1'b0; out_ready = 1'b0; flit_in = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  logic [16:0] got [$];
  logic        acc;

  initial begin
    reset_n = 1'b0; flit_valid = 1'b0; out_ready = 1'b0; flit_in = '0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flit_ready", 32'(flit_ready), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_errs", {30'd0, err_orphan, err_len}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_after_release", 32'(flit_ready), 32'd1);

    //          vld  mark pay      aux    ov  od       ol  oa  eo  el  pc
    tbl[0]  = mk(1, HM, 16'h1111, 16'd3, 1, 16'h1111, 0, 0, 0, 0, 16'd0);
    tbl[1]  = mk(1, BM, 16'h2222, 16'd0, 1, 16'h2222, 0, 0, 0, 0, 16'd0);
    tbl[2]  = mk(1, TM, 16'h3333, 16'd0, 1, 16'h3333, 1, 0, 0, 0, 16'd1);
    tbl[3]  = mk(0, BM, 16'h0000, 16'd0, 0, 16'h0000, 0, 0, 0, 0, 16'd1);
    tbl[4]  = mk(1, TM, 16'h5555, 16'd0, 0, 16'h0000, 0, 0, 1, 0, 16'd1);
    tbl[5]  = mk(0, BM, 16'h0000, 16'd0, 0, 16'h0000, 0, 0, 0, 0, 16'd1);
    tbl[6]  = mk(1, HM, 16'h00A1, 16'd4, 1, 16'h00A1, 0, 0, 0, 0, 16'd1);
    tbl[7]  = mk(1, BM, 16'h00A2, 16'd0, 1, 16'h00A2, 0, 0, 0, 0, 16'd1);
    tbl[8]  = mk(1, HM, 16'h00B1, 16'd2, 1, 16'h0000, 1, 1, 0, 1, 16'd1);
    tbl[9]  = mk(1, TM, 16'h00B2, 16'd0, 1, 16'h00B1, 0, 0, 0, 0, 16'd2);
    tbl[10] = mk(0, BM, 16'h0000, 16'd0, 1, 16'h00B2, 1, 0, 0, 0, 16'd2);
    tbl[11] = mk(0, BM, 16'h0000, 16'd0, 0, 16'h0000, 0, 0, 0, 0, 16'd2);
    tbl[12] = mk(1, HM, 16'h00C1, 16'd5, 1, 16'h00C1, 0, 0, 0, 0, 16'd2);
    tbl[13] = mk(1, TM, 16'h00C2, 16'd0, 1, 16'h00C2, 1, 0, 0, 1, 16'd3);
    tbl[14] = mk(0, BM, 16'h0000, 16'd0, 0, 16'h0000, 0, 0, 0, 0, 16'd3);
    tbl[15] = mk(1, HM, 16'h00D1, 16'd1, 1, 16'h00D1, 0, 0, 0, 0, 16'd3);
    tbl[16] = mk(1, TM, 16'h00D2, 16'd0, 1, 16'h00D2, 1, 0, 0, 1, 16'd4);
    tbl[17] = mk(0, BM, 16'h0000, 16'd0, 0, 16'h0000, 0, 0, 0, 0, 16'd4);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      flit_valid = tbl[i].vld;
      flit_in    = {tbl[i].mark, tbl[i].pay, tbl[i].aux};
      out_ready  = tbl[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
      chk($sformatf("v%0d_out_last", i), 32'(out_last), 32'(tbl[i].e_ol));
      chk($sformatf("v%0d_out_abort", i), 32'(out_abort), 32'(tbl[i].e_oa));
      chk($sformatf("v%0d_err_orphan", i), 32'(err_orphan), 32'(tbl[i].e_eo));
      chk($sformatf("v%0d_err_len", i), 32'(err_len), 32'(tbl[i].e_el));
      chk($sformatf("v%0d_flit_ready", i), 32'(flit_ready), 32'(tbl[i].e_fr));
      chk($sformatf("v%0d_pkt_count", i), 32'(pkt_count), 32'(tbl[i].e_pc));
    end

    // Backpressure: 7 flits fill the FIFO to 7, 8th waits until space frees.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      flit_valid = 1'b1;
      flit_in = {(i == 0) ? HM : BM, 16'hE000 + 16'(i), (i == 0) ? 16'd8 : 16'd0};
      @(negedge clk);
      chk($sformatf("bp_ready_occ%0d", i + 1), 32'(flit_ready), (i + 1 < 7) ? 32'd1 : 32'd0);
    end
    chk("bp_head_word", 32'(out_data), 32'hE000);
    flit_in = {TM, 16'hE007, 16'd0};
    out_ready = 1'b1;
    acc = 1'b0;
    got.delete();
    for (int c = 0; c < 40 && got.size() < 8; c++) begin
      if (out_valid) got.push_back({out_last, out_data});
      acc = flit_valid && flit_ready;
      @(negedge clk);
      if (acc) flit_valid = 1'b0;
    end
    chk("bp_word_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("bp_word%0d", i), 32'(got[i]), {15'd0, (i == 7) ? 1'b1 : 1'b0, 16'hE000 + 16'(i)});
    chk("bp_pkt_count", 32'(pkt_count), 32'd1);
    chk("bp_no_err_len", 32'(err_len), 32'd0);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Mid-packet reset with 3 words buffered.
    do_reset();
    flit_valid = 1'b1;
    flit_in = {HM, 16'h00F1, 16'd5}; @(negedge clk);
    flit_in = {BM, 16'h00F2, 16'd0}; @(negedge clk);
    flit_in = {BM, 16'h00F3, 16'd0}; @(negedge clk);
    flit_valid = 1'b0;
    chk("mr_buffered", 32'(out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_out_data", 32'(out_data), 32'd0);
    chk("mr_flit_ready", 32'(flit_ready), 32'd0);
    chk("mr_pkt_count", 32'(pkt_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("mr_ready_release", 32'(flit_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    flit_valid = 1'b1;
    flit_in = {HM, 16'h00C7, 16'd2};
    @(posedge clk); #1;
    chk("mr_new_head", 32'(out_data), 32'h00C7);
    chk("mr_new_head_abort", 32'(out_abort), 32'd0);
    @(negedge clk);
    flit_in = {TM, 16'h00C8, 16'd0};
    @(posedge clk); #1;
    chk("mr_new_tail", {15'd0, out_last, out_data}, {15'd0, 1'b1, 16'h00C8});
    chk("mr_new_pkt_count", 32'(pkt_count), 32'd1);
    chk("mr_new_err_len", 32'(err_len), 32'd0);
    @(negedge clk);
    flit_valid = 1'b0;
    @(negedge clk);
    chk("mr_empty_after", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/depacketizer_stream.md
Name: depacketizer_stream

Overview:
- Parametrised successor to the single-word depacketizer.
- Accepts a stream of fixed-format flits (head/body/tail) under a valid/ready handshake and tracks packet framing with a state machine.
- Checks declared packet length and buffers reassembled payload words in an internal FIFO.
- Emits payload words downstream with last/abort markers.
- Sits between the NoC router ejection port and the consumer core.

Parameters:
- DATA_W, 16, payload word width; a flit is 3*DATA_W bits.
- DEPTH, 8, output FIFO depth in words; power of 2, >= 4.
- HEAD_MARK, 16'hAAAA, marker-field value identifying a head flit (DATA_W bits).
- TAIL_MARK, 16'hFFFF, marker-field value identifying a tail flit (DATA_W bits).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flit_in  in  3*DATA_W  flit; [3W-1:2W]=marker, [2W-1:W]=payload, [W-1:0]=aux (head: total flit count incl. head and tail; ignored otherwise).
- flit_valid  in  1  flit_in valid.
- flit_ready  out  1  block can accept a flit this cycle.
- out_data  out  DATA_W  FIFO head payload word.
- out_last  out  1  word is final word of a packet.
- out_abort  out  1  word is an abort filler (packet truncated); out_data=0.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts word.
- err_orphan  out  1  one-cycle pulse: body/tail flit accepted while IDLE.
- err_len  out  1  one-cycle pulse: tail count differs from declared length.
- pkt_count  out  16  count of tail flits accepted with last=1, wraps at 2^16.

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE, FIFO empty, flit_count=0, len_reg=0, pkt_count=0; all outputs 0 except flit_ready=0 during reset and =1 on the first cycle after release.
- Flit classification: marker==HEAD_MARK -> HEAD; ==TAIL_MARK -> TAIL; else BODY.
- Handshake: flit accepted when flit_valid && flit_ready.
  - flit_ready = (FIFO free entries >= 2), computed from registered occupancy (pop in same cycle is not credited).
  - out word popped when out_valid && out_ready.
  - Push and pop in the same cycle are both honoured.
- FIFO entry = {abort, last, data}; outputs driven from the FIFO head (zero added latency once written); an accepted flit's word is visible on out_* the next cycle at the earliest.
- FSM states IDLE, IN_PKT:
  - IDLE + HEAD: push {0,0,payload}; len_reg<=aux; flit_count<=1; -> IN_PKT.
  - IDLE + BODY/TAIL: drop flit, err_orphan pulse, stay IDLE.
  - IN_PKT + BODY: push {0,0,payload}; flit_count+1.
  - IN_PKT + TAIL: push {0,1,payload}; pkt_count+1; err_len pulse if flit_count+1 != len_reg; -> IDLE.
  - IN_PKT + HEAD (truncation): push {1,1,0} then {0,0,payload} in the same cycle (two writes, hence the 2-entry ready rule); err_len pulse; reload len_reg/flit_count=1; stay IN_PKT.
- Head with aux<2: accepted; err_len fires at the tail regardless of count.
- flit_count saturates at 2^DATA_W-1 (no wrap); a saturated count always mismatches unless len_reg equals max.
- Error pulses are registered, asserted the cycle after acceptance, high for exactly one cycle.
- Mid-packet reset: FIFO contents discarded; no abort word emitted; FSM returns to IDLE.

Test Plan:
- Head(aux=3,pay=0x1111), body(0x2222), tail(0x3333), out_ready=1 -> out words 0x1111/0x2222/0x3333, out_last only on 0x3333, pkt_count=1, no errors.
- Tail flit while IDLE -> flit dropped, err_orphan one-cycle pulse, out_valid stays 0.
- Head(aux=4,pay=0xA1), body(0xA2), head(aux=2,pay=0xB1), tail(0xB2) -> outputs 0xA1, 0xA2, {abort,last,0}, 0xB1, 0xB2(last); one err_len pulse at 2nd head; pkt_count=1.
- Head(aux=5), tail (count 2) -> tail word with last=1, err_len pulse, pkt_count increments.
- out_ready=0, stream 8 words with DEPTH=8 -> flit_ready drops when occupancy reaches 7; no word lost or duplicated after out_ready=1.
- Assert reset_n=0 mid-packet with 3 words buffered -> out_valid=0 immediately, pkt_count=0; next head after release starts a clean packet.
